// File: rtl/gen_osc.sv
// gen_osc: phase-accumulator oscillator (saw/square/triangle/silence) with hard sync and sequential increment divider
module gen_osc #(
    parameter int OUT_W   = 24,
    parameter int PHASE_W = 32,
    parameter int FREQ_W  = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [31:0]       sys_clk_freq,
    input  logic [FREQ_W-1:0] freq,
    input  logic [1:0]        mode,
    input  logic              enable,
    input  logic              sync,
    output logic [OUT_W-1:0]  out,
    output logic              wrap,
    output logic              busy
);
    localparam int DW = PHASE_W + FREQ_W;
    localparam int CW = $clog2(DW);
    logic [PHASE_W-1:0] phase, inc, phase_nx, inc_nx;
    logic               carry, sync_d, pending, start, clamp;
    logic [FREQ_W-1:0]  freq_q;
    logic [31:0]        clk_q, rem, rem_nx;
    logic [DW-1:0]      dvd, dvd_nx;
    logic [32:0]        rem_sh, diff, f2;
    logic [CW-1:0]      cnt;
    logic [OUT_W-1:0]   tri_w;
    always_comb begin
        start  = pending | (freq != freq_q) | (sys_clk_freq != clk_q);
        rem_sh = {rem, dvd[DW-1]};
        diff   = rem_sh - {1'b0, clk_q};
        dvd_nx = {dvd[DW-2:0], ~diff[32]};
        rem_nx = diff[32] ? rem_sh[31:0] : diff[31:0];
        f2     = 33'(freq_q) << 1;
        clamp  = f2 >= {1'b0, clk_q};
        inc_nx = (clk_q == 32'd0) ? '0 : clamp ? {1'b1, {(PHASE_W-1){1'b0}}} : dvd_nx[PHASE_W-1:0];
        {carry, phase_nx} = {1'b0, phase} + {1'b0, inc};
        tri_w  = phase[PHASE_W-1] ? ~phase[PHASE_W-2 -: OUT_W] : phase[PHASE_W-2 -: OUT_W];
    end
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            phase   <= '0;
            inc     <= '0;
            out     <= '0;
            wrap    <= 1'b0;
            busy    <= 1'b0;
            sync_d  <= 1'b0;
            pending <= 1'b1;
            freq_q  <= '0;
            clk_q   <= '0;
            dvd     <= '0;
            rem     <= '0;
            cnt     <= '0;
        end else begin
            sync_d <= sync;
            if (sync & ~sync_d) begin
                phase <= '0;
                wrap  <= 1'b1;
            end else if (enable) begin
                phase <= phase_nx;
                wrap  <= carry;
            end else begin
                wrap  <= 1'b0;
            end
            out <= (mode == 2'd0) ? phase[PHASE_W-1 -: OUT_W] :
                   (mode == 2'd1) ? {OUT_W{phase[PHASE_W-1]}} :
                   (mode == 2'd2) ? tri_w : {1'b1, {(OUT_W-1){1'b0}}};
            if (start) begin
                pending <= 1'b0;
                freq_q  <= freq;
                clk_q   <= sys_clk_freq;
                busy    <= 1'b1;
                rem     <= '0;
                dvd     <= {freq, {PHASE_W{1'b0}}};
                cnt     <= (sys_clk_freq == 32'd0) ? '0 : CW'(DW - 1);
            end else if (busy) begin
                dvd <= dvd_nx;
                rem <= rem_nx;
                cnt <= cnt - 1'b1;
                if (cnt == '0) begin
                    busy <= 1'b0;
                    inc  <= inc_nx;
                end
            end
        end
    end
endmodule

// File: tb/tb_gen_osc.sv
// tb_gen_osc: directed self-checking bench for gen_osc
module tb_gen_osc;
    logic        sys_clk = 1'b0, sys_rst = 1'b1, enable = 1'b0, sync = 1'b0;
    logic [31:0] sys_clk_freq = 32'd1024;
    logic [15:0] freq = 16'd1;
    logic [1:0]  mode = 2'd0;
    logic [23:0] out, o0, d;
    logic        wrap, busy;
    int          n_chk = 0, n_pass = 0, n;

    gen_osc dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .sys_clk_freq(sys_clk_freq), .freq(freq),
        .mode(mode), .enable(enable), .sync(sync), .out(out), .wrap(wrap), .busy(busy)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got %0h exp %0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic wait_idle(output int c);
        c = 0;
        while (busy && c < 500) begin
            c++;
            tick();
        end
    endtask

    task automatic wait_wrap(output int c);
        c = 0;
        do begin
            tick();
            c++;
        end while (!wrap && c < 2000);
    endtask

    task automatic sync_pulse;
        sync = 1'b1;
        tick();
        sync = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        chk("rst_out", out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wrap", wrap, 0);
        chk("rst_inc", dut.inc, 0);
        chk("rst_phase", dut.phase, 0);
        sys_rst = 1'b0;
        tick();
        chk("div_start", busy, 1);
        wait_idle(n);
        chk("busy_len", n, 48);
        chk("inc_1024", dut.inc, 32'h0040_0000);
        enable = 1'b1;
        repeat (3) tick();
        o0 = out;
        tick();
        d = out - o0;
        chk("saw_step1", d, 24'h4000);
        o0 = out;
        tick();
        d = out - o0;
        chk("saw_step2", d, 24'h4000);
        wait_wrap(n);
        chk("wrap_found", wrap, 1);
        wait_wrap(n);
        chk("wrap_period", n, 1024);

        enable = 1'b0;
        freq = 16'd440;
        sys_clk_freq = 32'd50_000_000;
        tick();
        chk("div440_start", busy, 1);
        wait_idle(n);
        chk("inc_440", dut.inc, 37795);
        sync_pulse();
        chk("sync_phase0", dut.phase, 0);
        chk("sync_wrap", wrap, 1);
        enable = 1'b1;
        repeat (1000) tick();
        enable = 1'b0;
        chk("phase_1000", dut.phase, 37_795_000);
        tick();
        chk("saw_440", out, 24'h0240B4);
        mode = 2'd1;
        tick();
        chk("sq_low", out, 0);
        mode = 2'd2;
        tick();
        chk("tri_440", out, 24'h048169);
        mode = 2'd3;
        tick();
        chk("silence", out, 24'h800000);

        freq = 16'd600;
        sys_clk_freq = 32'd1000;
        tick();
        wait_idle(n);
        chk("inc_clamp", dut.inc, 32'h8000_0000);
        sync_pulse();
        mode = 2'd1;
        enable = 1'b1;
        tick();
        chk("sq_ph0", out, 0);
        tick();
        chk("sq_ph80", out, 24'hFFFFFF);
        chk("clamp_wrap", wrap, 1);
        mode = 2'd2;
        tick();
        chk("tri_ph0", out, 0);
        tick();
        chk("tri_ph80", out, 24'hFFFFFF);

        enable = 1'b0;
        sys_clk_freq = 32'd0;
        tick();
        wait_idle(n);
        chk("zero_busy", n, 1);
        chk("zero_inc", dut.inc, 0);
        sync_pulse();
        mode = 2'd0;
        enable = 1'b1;
        repeat (5) tick();
        chk("zero_out", out, 0);
        chk("zero_phase", dut.phase, 0);

        enable = 1'b0;
        freq = 16'd1;
        sys_clk_freq = 32'd1024;
        tick();
        repeat (9) tick();
        chk("restart_busy", busy, 1);
        chk("old_inc", dut.inc, 0);
        freq = 16'd2;
        tick();
        wait_idle(n);
        chk("restart_len", n, 48);
        chk("inc_2", dut.inc, 32'h0080_0000);

        enable = 1'b1;
        repeat (3) tick();
        chk("pre_sync", dut.phase, 32'h0180_0000);
        sync = 1'b1;
        tick();
        chk("hs_phase1", dut.phase, 0);
        chk("hs_wrap1", wrap, 1);
        tick();
        chk("hs_phase2", dut.phase, 32'h0080_0000);
        chk("hs_wrap2", wrap, 0);
        tick();
        sync = 1'b0;
        chk("hs_phase3", dut.phase, 32'h0100_0000);
        tick();
        chk("hs_resume", dut.phase, 32'h0180_0000);

        sys_rst = 1'b1;
        tick();
        chk("mrst_out", out, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_phase", dut.phase, 0);
        sys_rst = 1'b0;
        tick();
        chk("mrst_div", busy, 1);
        wait_idle(n);
        chk("mrst_len", n, 48);
        chk("mrst_inc", dut.inc, 32'h0080_0000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/gen_osc.md
Name: gen_osc

Overview:
Parametrised multi-waveform phase-accumulator oscillator. It supersedes the single-mode sawtooth generator in the audio synthesis path.
Provides saw, square, triangle and silence modes, and hard-sync phase reset. Increment is computed with a sequential divider instead of a combinational one, and the phase accumulator is full-width.
Output feeds the mixer/DAC sample path as unsigned OUT_W-bit samples.

Parameters:
OUT_W, 24, sample width
PHASE_W, 32, phase accumulator width (must be > OUT_W)
FREQ_W, 16, frequency input width in Hz

Ports:
sys_clk  in  1  system clock (only clock)
sys_rst  in  1  synchronous reset, active-high
sys_clk_freq  in  32  sys_clk frequency in Hz
freq  in  FREQ_W  requested output frequency in Hz
mode  in  2  00 saw, 01 square, 10 triangle, 11 silence
enable  in  1  1 = phase advances
sync  in  1  hard sync; rising edge resets phase
out  out  OUT_W  unsigned sample, registered
wrap  out  1  one-cycle pulse when phase wraps or is synced
busy  out  1  1 while increment division is in progress

Behaviour:
- Reset (sys_rst=1 at posedge): phase=0, inc=0, out=0, wrap=0, busy=0, sync_d=0, pending=1. All state is cleared in the same cycle; reset mid-division aborts it.
- Increment: inc = floor(freq * 2^PHASE_W / sys_clk_freq), truncated to PHASE_W bits.
- Division is restoring, one quotient bit per cycle, with DIV_CYCLES = PHASE_W+FREQ_W.
- Division starts on the cycle after pending=1 or after a change of freq/sys_clk_freq. Inputs are compared against copies registered at the last start.
- busy=1 from the start cycle until the result is loaded. inc is updated in the cycle busy falls.
- If inputs change while busy, the current division is aborted and a new one starts on the next cycle. Old inc stays in use until a division completes.
- sys_clk_freq=0: inc=0 after 1 cycle of busy, with no division.
- Saturation: if freq*2 >= sys_clk_freq, inc = 2^(PHASE_W-1) (Nyquist clamp).
- Phase, per cycle:
  - Sync edge (sync=1, sync_d=0): phase <= 0, wrap=1. Sync has priority over enable.
  - Otherwise, if enable=1: phase <= phase+inc modulo 2^PHASE_W, and wrap=1 iff the addition carries out.
  - Otherwise phase holds and wrap=0.
- Output is registered from the current phase, giving 1-cycle latency phase->out. Let P = phase[PHASE_W-1] and T = phase[PHASE_W-2 -: OUT_W].
  - Saw: phase[PHASE_W-1 -: OUT_W].
  - Square: P ? all-ones : 0.
  - Triangle: P ? ~T : T. Peak all-ones at phase 0x7FF..F and 0x800..0.
  - Silence: constant 2^(OUT_W-1) (midscale). Phase keeps running.
- A mode change takes effect on the next out update. There is no phase disturbance on mode change.

Test Plan:
- Reset, then sys_clk_freq=1024, freq=1, defaults -> busy=1 for 48 cycles, then inc=0x0040_0000. With enable=1 and saw mode, out steps +0x4000 per cycle and wrap pulses every 1024 cycles.
- sys_clk_freq=50_000_000, freq=440 -> after busy falls, inc=37795. Phase after 1000 enabled cycles = 37_795_000.
- Same setup, square then triangle -> square out=0xFFFFFF exactly while phase>=0x8000_0000. Triangle out=0xFFFFFF at phase 0x8000_0000, and 0 at phase 0.
- freq changed 1->2 at cycle 10 of a busy division -> division restarts (busy stays 1 for 48 more cycles). Old inc stays in use until final inc=0x0080_0000.
- freq=600, sys_clk_freq=1000 -> inc=0x8000_0000 (clamp). sys_clk_freq=0 -> inc=0, out constant.
- sync pulse high 3 cycles while enable=1 -> phase=0 and wrap=1 on the first cycle only, then counting resumes. Assert sys_rst mid-count -> out=0, busy=0 on the next cycle, then re-division starts.
